usb_vf_source_sched: RTL and testbench

// - Frame-level scheduler between usb_camera_top's video-frame fetch port (vf_sof/vf_req/vf_byte) and two pixel sources:
//   an internal test pattern and an external byte stream (s_*).
// - Selects the source per frame, switching only at vf_sof. Aligns the external stream to frame starts.
// - Counts bytes against the frame size and substitutes a fill byte on underrun or overlength requests.

---
 rtl/usb_vf_source_sched_pkg.sv | 23 ++
 rtl/usb_vf_source_sched_pattern.sv | 29 ++
 rtl/usb_vf_source_sched.sv | 165 ++++++++++++++++
 tb/tb_usb_vf_source_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_vf_source_sched_pkg.sv
// Shared types and constants for the video-frame source scheduler:
// scheduler states, source select encodings and the frame-size derivation.
package usb_vf_source_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } vf_state_t;

  localparam logic SRC_PATTERN = 1'b0;
  localparam logic SRC_EXT     = 1'b1;

  function automatic logic [28:0] frame_bytes(input logic [13:0] w,
                                              input logic [13:0] h,
                                              input logic [1:0]  bpp);
    logic [28:0] r;
    r = 29'(w) * 29'(h) * 29'(bpp);
    return r;
  endfunction

endpackage

// File: rtl/usb_vf_source_sched_pattern.sv
// Test-pattern generator: a per-frame base register plus the low byte of the
// frame byte counter. The first pattern frame after reset starts at base 0.
module usb_vf_pattern_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       sof,
  input  logic       pattern_sel,
  input  logic [7:0] bcnt_lo,
  output logic [7:0] pat_byte
);

  logic [7:0] base;
  logic       armed;

  // armed suppresses the increment on the very first pattern frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base  <= '0;
      armed <= 1'b0;
    end else if (sof && pattern_sel) begin
      armed <= 1'b1;
      if (armed)
        base <= base + 8'd1;
    end
  end

  assign pat_byte = base + bcnt_lo;

endmodule

// File: rtl/usb_vf_source_sched.sv
// Frame scheduler between the camera's video-frame fetch port and two pixel
// sources (test pattern / external stream). Optional stats: VF_SCHED_STATS_EN.
module usb_vf_source_sched
  import usb_vf_source_sched_pkg::*;
#(
  parameter logic [13:0] FRAME_W = 14'd252,
  parameter logic [13:0] FRAME_H = 14'd120,
  parameter logic [1:0]  BPP     = 2'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_src_sel,
  input  logic [7:0]  cfg_fill,
  input  logic        vf_sof,
  input  logic        vf_req,
  output logic [7:0]  vf_byte,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_first,
  output logic        s_ready,
  output logic        active_src,
  output logic        frame_active,
  output logic        underrun,
  output logic        overrun,
  output logic        short_frame
`ifdef VF_SCHED_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [28:0] FRAME_BYTES = frame_bytes(FRAME_W, FRAME_H, BPP);

  vf_state_t   state, state_nxt;
  logic [28:0] bcnt;
  logic [7:0]  pat_byte;
  logic [7:0]  byte_nxt;
  logic        under_nxt, over_nxt, short_nxt, bcnt_inc;
  logic        last_byte;
  logic        in_frame;

  assign last_byte = ((bcnt + 29'd1) == FRAME_BYTES);
  assign in_frame  = (state == SYNC) || (state == STREAM);
  assign short_nxt = vf_sof && in_frame;

  usb_vf_pattern_gen u_pattern (
    .clk         (clk),
    .rst         (rst),
    .sof         (vf_sof),
    .pattern_sel (cfg_src_sel == SRC_PATTERN),
    .bcnt_lo     (bcnt[7:0]),
    .pat_byte    (pat_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vf_sof) begin
      state_nxt = (cfg_src_sel == SRC_EXT) ? SYNC : STREAM;
    end else begin
      case (state)
        SYNC: begin
          if (vf_req && last_byte)
            state_nxt = DONE;
          else if (s_valid && s_first)
            state_nxt = STREAM;
        end
        STREAM: begin
          if (vf_req && last_byte)
            state_nxt = DONE;
        end
        default: ;
      endcase
    end
  end

  // vf_sof masks every request-side effect so a coincident vf_req is dropped
  always_comb begin
    s_ready   = 1'b0;
    byte_nxt  = vf_byte;
    under_nxt = 1'b0;
    over_nxt  = 1'b0;
    bcnt_inc  = 1'b0;
    if (!vf_sof) begin
      case (state)
        SYNC: begin
          s_ready = s_valid & ~s_first;
          if (vf_req) begin
            byte_nxt  = cfg_fill;
            under_nxt = 1'b1;
            bcnt_inc  = 1'b1;
          end
        end
        STREAM: begin
          if (active_src == SRC_EXT)
            s_ready = vf_req & s_valid;
          if (vf_req) begin
            bcnt_inc = 1'b1;
            if (active_src == SRC_PATTERN) begin
              byte_nxt = pat_byte;
            end else if (s_valid) begin
              byte_nxt = s_data;
            end else begin
              byte_nxt  = cfg_fill;
              under_nxt = 1'b1;
            end
          end
        end
        DONE: begin
          if (vf_req) begin
            byte_nxt = cfg_fill;
            over_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_active = in_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt        <= '0;
      vf_byte     <= '0;
      active_src  <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      vf_byte     <= byte_nxt;
      underrun    <= under_nxt;
      overrun     <= over_nxt;
      short_frame <= short_nxt;
      if (vf_sof) begin
        bcnt       <= '0;
        active_src <= cfg_src_sel;
      end else if (bcnt_inc) begin
        bcnt <= bcnt + 29'd1;
      end
    end
  end

`ifdef VF_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (vf_sof)
        frame_cnt <= frame_cnt + 16'd1;
      if ((under_nxt || over_nxt || short_nxt) && (err_cnt != '1))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_vf_source_sched.sv
// Directed self-checking bench for usb_vf_source_sched with a 4-byte frame.
module tb_usb_vf_source_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_src_sel;
  logic [7:0] cfg_fill;
  logic       vf_sof, vf_req;
  logic [7:0] vf_byte;
  logic       s_valid, s_first;
  logic [7:0] s_data;
  logic       s_ready, active_src, frame_active, underrun, overrun, short_frame;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usb_vf_source_sched #(
    .FRAME_W (14'd2),
    .FRAME_H (14'd2),
    .BPP     (2'd1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_src_sel  (cfg_src_sel),
    .cfg_fill     (cfg_fill),
    .vf_sof       (vf_sof),
    .vf_req       (vf_req),
    .vf_byte      (vf_byte),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_first      (s_first),
    .s_ready      (s_ready),
    .active_src   (active_src),
    .frame_active (frame_active),
    .underrun     (underrun),
    .overrun      (overrun),
    .short_frame  (short_frame)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sof(input logic sel);
    cfg_src_sel = sel;
    vf_sof = 1'b1;
    tick();
    vf_sof = 1'b0;
  endtask

  task automatic do_req();
    vf_req = 1'b1;
    tick();
    vf_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({vf_byte, s_ready, active_src, frame_active, underrun, overrun, short_frame} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {vf_byte, s_ready, active_src, frame_active, underrun, overrun, short_frame});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (frame_active !== 1'b0) begin
      n_err++;
      $display("FAIL idle_frame_active: got %b want 0", frame_active);
    end
  endtask

  task automatic test_pattern();
    logic [7:0] exp;
    for (int f = 0; f < 2; f++) begin
      do_sof(1'b0);
      n_cmp++;
      if (active_src !== 1'b0 || frame_active !== 1'b1 || short_frame !== 1'b0) begin
        n_err++;
        $display("FAIL pat_sof f%0d: src=%b act=%b short=%b want 0 1 0", f, active_src, frame_active, short_frame);
      end
      for (int i = 0; i < 4; i++) begin
        exp = 8'(f + i);
        do_req();
        n_cmp++;
        if (vf_byte !== exp || underrun !== 1'b0 || overrun !== 1'b0) begin
          n_err++;
          $display("FAIL pat_byte f%0d i%0d: got %h u=%b o=%b want %h 0 0", f, i, vf_byte, underrun, overrun, exp);
        end
      end
      n_cmp++;
      if (frame_active !== 1'b0) begin
        n_err++;
        $display("FAIL pat_done f%0d: frame_active=%b want 0", f, frame_active);
      end
    end
  endtask

  task automatic test_src_switch_midframe();
    logic [7:0] exp;
    do_sof(1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) cfg_src_sel = 1'b1;
      exp = 8'(2 + i);
      do_req();
      n_cmp++;
      if (vf_byte !== exp || active_src !== 1'b0) begin
        n_err++;
        $display("FAIL switch_hold i%0d: byte=%h src=%b want %h 0", i, vf_byte, active_src, exp);
      end
    end
    do_sof(1'b1);
    n_cmp++;
    if (active_src !== 1'b1 || short_frame !== 1'b0) begin
      n_err++;
      $display("FAIL switch_apply: src=%b short=%b want 1 0", active_src, short_frame);
    end
  endtask

  task automatic test_ext_stream();
    logic [7:0] d [4];
    d[0] = 8'h10; d[1] = 8'h11; d[2] = 8'h12; d[3] = 8'h13;
    s_valid = 1'b1; s_first = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_data = (i == 0) ? 8'hAA : 8'hBB;
      #1;
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_err++;
        $display("FAIL sync_discard i%0d: s_ready=%b want 1", i, s_ready);
      end
      tick();
    end
    s_data = 8'h10; s_first = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL sync_first_hold: s_ready=%b want 0", s_ready);
    end
    tick();
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stream_noreq_ready: s_ready=%b want 0", s_ready);
    end
    for (int i = 0; i < 4; i++) begin
      s_data = d[i];
      s_first = (i == 0);
      vf_req = 1'b1;
      #1;
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_err++;
        $display("FAIL ext_ready i%0d: s_ready=%b want 1", i, s_ready);
      end
      tick();
      vf_req = 1'b0;
      n_cmp++;
      if (vf_byte !== d[i] || underrun !== 1'b0) begin
        n_err++;
        $display("FAIL ext_byte i%0d: got %h u=%b want %h 0", i, vf_byte, underrun, d[i]);
      end
    end
    s_valid = 1'b0; s_first = 1'b0;
    n_cmp++;
    if (frame_active !== 1'b0) begin
      n_err++;
      $display("FAIL ext_done: frame_active=%b want 0", frame_active);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] eb [4];
    logic       eu [4];
    logic [7:0] sd [4];
    eb[0] = 8'h10; eb[1] = 8'h11; eb[2] = 8'h80; eb[3] = 8'h12;
    eu[0] = 1'b0;  eu[1] = 1'b0;  eu[2] = 1'b1;  eu[3] = 1'b0;
    sd[0] = 8'h10; sd[1] = 8'h11; sd[2] = 8'h00; sd[3] = 8'h12;
    cfg_fill = 8'h80;
    do_sof(1'b1);
    n_cmp++;
    if (short_frame !== 1'b0 || active_src !== 1'b1) begin
      n_err++;
      $display("FAIL under_sof: short=%b src=%b want 0 1", short_frame, active_src);
    end
    s_valid = 1'b1; s_first = 1'b1; s_data = 8'h10;
    tick();
    for (int i = 0; i < 4; i++) begin
      s_valid = (i != 2);
      s_first = (i == 0);
      s_data = sd[i];
      do_req();
      n_cmp++;
      if (vf_byte !== eb[i] || underrun !== eu[i]) begin
        n_err++;
        $display("FAIL under_byte i%0d: got %h u=%b want %h %b", i, vf_byte, underrun, eb[i], eu[i]);
      end
    end
    s_valid = 1'b0; s_first = 1'b0;
  endtask

  task automatic test_overrun_short();
    do_req();
    n_cmp++;
    if (vf_byte !== 8'h80 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun: byte=%h o=%b want 80 1", vf_byte, overrun);
    end
    tick();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_pulse: o=%b want 0", overrun);
    end
    do_sof(1'b0);
    for (int i = 0; i < 2; i++) begin
      do_req();
      n_cmp++;
      if (vf_byte !== 8'(3 + i)) begin
        n_err++;
        $display("FAIL short_pat i%0d: got %h want %h", i, vf_byte, 8'(3 + i));
      end
    end
    do_sof(1'b1);
    n_cmp++;
    if (short_frame !== 1'b1) begin
      n_err++;
      $display("FAIL short_stream: short=%b want 1", short_frame);
    end
    do_req();
    n_cmp++;
    if (short_frame !== 1'b0 || vf_byte !== 8'h80 || underrun !== 1'b1) begin
      n_err++;
      $display("FAIL sync_req: short=%b byte=%h u=%b want 0 80 1", short_frame, vf_byte, underrun);
    end
  endtask

  task automatic test_reset_midframe();
    do_sof(1'b1);
    n_cmp++;
    if (short_frame !== 1'b1) begin
      n_err++;
      $display("FAIL short_sync: short=%b want 1", short_frame);
    end
    s_valid = 1'b1; s_first = 1'b1; s_data = 8'h10;
    tick();
    do_req();
    s_first = 1'b0; s_data = 8'h11;
    do_req();
    n_cmp++;
    if (vf_byte !== 8'h11) begin
      n_err++;
      $display("FAIL rst_pre: byte=%h want 11", vf_byte);
    end
    vf_req = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({vf_byte, s_ready, active_src, frame_active, underrun, overrun, short_frame} !== 14'd0) begin
      n_err++;
      $display("FAIL rst_async: got %h want 0",
               {vf_byte, s_ready, active_src, frame_active, underrun, overrun, short_frame});
    end
    tick();
    rst = 1'b0; vf_req = 1'b0; s_valid = 1'b0;
    tick();
    do_sof(1'b0);
    for (int i = 0; i < 2; i++) begin
      do_req();
      n_cmp++;
      if (vf_byte !== 8'(i)) begin
        n_err++;
        $display("FAIL rst_base i%0d: got %h want %h", i, vf_byte, 8'(i));
      end
    end
    vf_sof = 1'b1; vf_req = 1'b1;
    tick();
    vf_sof = 1'b0; vf_req = 1'b0;
    n_cmp++;
    if (vf_byte !== 8'h01 || short_frame !== 1'b1 || underrun !== 1'b0) begin
      n_err++;
      $display("FAIL sof_req_drop: byte=%h short=%b u=%b want 01 1 0", vf_byte, short_frame, underrun);
    end
    do_req();
    n_cmp++;
    if (vf_byte !== 8'h01) begin
      n_err++;
      $display("FAIL sof_req_bcnt0: got %h want 01", vf_byte);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_src_sel = 1'b0; cfg_fill = 8'h00;
    vf_sof = 1'b0; vf_req = 1'b0;
    s_valid = 1'b0; s_first = 1'b0; s_data = 8'h00;
    test_reset();
    test_pattern();
    test_src_switch_midframe();
    test_ext_stream();
    test_underrun();
    test_overrun_short();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
